// File: rtl/ssd1351_fill_engine.sv
// SSD1351 rectangle-fill / fast-clear sequencer feeding the SPI byte driver.
// Build option: define OLED_FILL_WINDOW_EN to store a window and emit column/row setup.
module ssd1351_fill_engine #(
    parameter int unsigned CNT_W    = 15,
    parameter logic [7:0]  CMD_COL  = 8'h15,
    parameter logic [7:0]  CMD_ROW  = 8'h75,
    parameter logic [7:0]  CMD_WRAM = 8'h5C
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wstrb,
    input  logic        sel_color,
    input  logic        sel_win,
    input  logic        sel_go,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        oled_wstrb,
    output logic        oled_cmd,
    output logic        oled_dat,
    output logic [7:0]  oled_byte,
    input  logic        oled_busy
);

    // state        | meaning
    // S_IDLE       | no fill in progress, GO accepted here
    // S_SETUP_ISS  | wait for driver idle, strobe setup byte setup_idx_q
    // S_SETUP_GRD  | strobe visible; driver raises wbusy next cycle
    // S_HI_ISS     | wait for driver idle, strobe colour[15:8]
    // S_HI_GRD     | strobe visible, hold one cycle
    // S_LO_ISS     | wait for driver idle, strobe colour[7:0]
    // S_LO_GRD     | strobe visible; pixel done, count down or finish
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SETUP_ISS = 3'd1,
        S_SETUP_GRD = 3'd2,
        S_HI_ISS    = 3'd3,
        S_HI_GRD    = 3'd4,
        S_LO_ISS    = 3'd5,
        S_LO_GRD    = 3'd6
    } state_t;

`ifdef OLED_FILL_WINDOW_EN
    localparam logic [2:0] SETUP_LAST = 3'd6;
`else
    localparam logic [2:0] SETUP_LAST = 3'd0;
`endif

    state_t           state_q, state_d;
    logic [2:0]       setup_idx_q, setup_idx_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [15:0]      colour_q;
    logic             wstrb_q, wstrb_d;
    logic             cmd_q, cmd_d;
    logic             dat_q, dat_d;
    logic [7:0]       byte_q, byte_d;
    logic [7:0]       setup_byte;
    logic             setup_is_cmd;
    logic             is_idle;
    logic             go_req;
    logic             abort_req;
    logic [CNT_W-1:0] go_count;

    assign is_idle   = (state_q == S_IDLE);
    assign go_count  = wdata[CNT_W-1:0];
    assign go_req    = wstrb & sel_go & ~wdata[31];
    assign abort_req = wstrb & sel_go & wdata[31];

    // Configuration is frozen while a fill runs so the stream stays self-consistent.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            colour_q <= '0;
        end else if (wstrb && sel_color && is_idle) begin
            colour_q <= wdata[15:0];
        end
    end

`ifdef OLED_FILL_WINDOW_EN
    logic [6:0] x0_q, x1_q, y0_q, y1_q;
    logic       unused_bits;

    assign unused_bits = ^{wdata[23], wdata[15], wdata[7]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x0_q <= '0;
            x1_q <= '0;
            y0_q <= '0;
            y1_q <= '0;
        end else if (wstrb && sel_win && is_idle) begin
            x0_q <= wdata[6:0];
            x1_q <= wdata[14:8];
            y0_q <= wdata[22:16];
            y1_q <= wdata[30:24];
        end
    end

    always_comb begin
        setup_byte   = CMD_WRAM;
        setup_is_cmd = 1'b1;
        case (setup_idx_q)
            3'd0: begin setup_byte = CMD_COL;        setup_is_cmd = 1'b1; end
            3'd1: begin setup_byte = {1'b0, x0_q};   setup_is_cmd = 1'b0; end
            3'd2: begin setup_byte = {1'b0, x1_q};   setup_is_cmd = 1'b0; end
            3'd3: begin setup_byte = CMD_ROW;        setup_is_cmd = 1'b1; end
            3'd4: begin setup_byte = {1'b0, y0_q};   setup_is_cmd = 1'b0; end
            3'd5: begin setup_byte = {1'b0, y1_q};   setup_is_cmd = 1'b0; end
            default: begin setup_byte = CMD_WRAM;    setup_is_cmd = 1'b1; end
        endcase
    end
`else
    logic unused_bits;

    assign unused_bits = ^{sel_win, wdata[30:16]};

    always_comb begin
        setup_byte   = CMD_WRAM;
        setup_is_cmd = 1'b1;
    end
`endif

    always_comb begin
        state_d     = state_q;
        setup_idx_d = setup_idx_q;
        count_d     = count_q;
        wstrb_d     = 1'b0;
        cmd_d       = 1'b0;
        dat_d       = 1'b0;
        byte_d      = byte_q;
        if (abort_req && !is_idle) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (go_req && (go_count != '0)) begin
                        state_d     = S_SETUP_ISS;
                        setup_idx_d = 3'd0;
                        count_d     = go_count;
                    end
                end
                S_SETUP_ISS: begin
                    if (!oled_busy) begin
                        wstrb_d = 1'b1;
                        cmd_d   = setup_is_cmd;
                        dat_d   = ~setup_is_cmd;
                        byte_d  = setup_byte;
                        state_d = S_SETUP_GRD;
                    end
                end
                S_SETUP_GRD: begin
                    if (setup_idx_q == SETUP_LAST) begin
                        state_d = S_HI_ISS;
                    end else begin
                        setup_idx_d = setup_idx_q + 3'd1;
                        state_d     = S_SETUP_ISS;
                    end
                end
                S_HI_ISS: begin
                    if (!oled_busy) begin
                        wstrb_d = 1'b1;
                        dat_d   = 1'b1;
                        byte_d  = colour_q[15:8];
                        state_d = S_HI_GRD;
                    end
                end
                S_HI_GRD: begin
                    state_d = S_LO_ISS;
                end
                S_LO_ISS: begin
                    if (!oled_busy) begin
                        wstrb_d = 1'b1;
                        dat_d   = 1'b1;
                        byte_d  = colour_q[7:0];
                        state_d = S_LO_GRD;
                    end
                end
                S_LO_GRD: begin
                    count_d = count_q - CNT_W'(1);
                    state_d = (count_q == CNT_W'(1)) ? S_IDLE : S_HI_ISS;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Driver-facing outputs are registered so reset clears them asynchronously.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            setup_idx_q <= '0;
            count_q     <= '0;
            wstrb_q     <= 1'b0;
            cmd_q       <= 1'b0;
            dat_q       <= 1'b0;
            byte_q      <= '0;
        end else begin
            state_q     <= state_d;
            setup_idx_q <= setup_idx_d;
            count_q     <= count_d;
            wstrb_q     <= wstrb_d;
            cmd_q       <= cmd_d;
            dat_q       <= dat_d;
            byte_q      <= byte_d;
        end
    end

    assign busy       = ~is_idle;
    assign oled_wstrb = wstrb_q;
    assign oled_cmd   = cmd_q;
    assign oled_dat   = dat_q;
    assign oled_byte  = byte_q;

endmodule

// File: tb/tb_ssd1351_fill_engine.sv
// Bench for ssd1351_fill_engine: driver model, expected-byte-stream model, random fills.
module tb_ssd1351_fill_engine;

    localparam logic [7:0] CMD_COL  = 8'h15;
    localparam logic [7:0] CMD_ROW  = 8'h75;
    localparam logic [7:0] CMD_WRAM = 8'h5C;
`ifdef OLED_FILL_WINDOW_EN
    localparam int SETUP_LEN = 7;
`else
    localparam int SETUP_LEN = 1;
`endif

    logic        clk;
    logic        resetn;
    logic        wstrb;
    logic        sel_color;
    logic        sel_win;
    logic        sel_go;
    logic [31:0] wdata;
    logic        busy;
    logic        oled_wstrb;
    logic        oled_cmd;
    logic        oled_dat;
    logic [7:0]  oled_byte;
    logic        oled_busy;

    logic hold_busy;
    int   drv_cnt = 0;
    int   drv_lat;

    logic [9:0]  exp_q[$];
    logic [9:0]  mon_e;
    logic [15:0] m_colour;
    logic [27:0] m_win;
    bit          m_active;
    int          n_checks = 0;
    int          n_pass = 0;
    int          n_strobes = 0;
    int          strobes_in_fill = 0;
    int          pix_seen = 0;
    int          cyc = 0;
    int          go_cyc = 0;
    int          last_strobe_cyc = 0;
    bit          first_pending = 0;
    bit          lat_chk = 0;
    bit          skip_fall = 1;
    bit          prev_wstrb = 0;
    bit          prev_busy = 0;

    ssd1351_fill_engine dut (
        .clk        (clk),
        .resetn     (resetn),
        .wstrb      (wstrb),
        .sel_color  (sel_color),
        .sel_win    (sel_win),
        .sel_go     (sel_go),
        .wdata      (wdata),
        .busy       (busy),
        .oled_wstrb (oled_wstrb),
        .oled_cmd   (oled_cmd),
        .oled_dat   (oled_dat),
        .oled_byte  (oled_byte),
        .oled_busy  (oled_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Driver: wbusy rises the cycle after a strobe and stays up drv_lat cycles.
    always @(posedge clk) begin
        if (oled_wstrb) drv_cnt <= drv_lat;
        else if (drv_cnt != 0) drv_cnt <= drv_cnt - 1;
    end
    assign oled_busy = hold_busy | (drv_cnt != 0);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (resetn) begin
            if (oled_wstrb) begin
                n_strobes++;
                strobes_in_fill++;
                if (strobes_in_fill > SETUP_LEN) pix_seen++;
                check("strobe_width", 32'(prev_wstrb), 0);
                check("strobe_vs_busy", 32'(oled_busy), 0);
                check("cmd_dat_excl", 32'(oled_cmd & oled_dat), 0);
                if (exp_q.size() == 0) begin
                    check("extra_strobe", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("byte", {22'd0, oled_cmd, oled_dat, oled_byte}, {22'd0, mon_e});
                    if (exp_q.size() == 0) m_active = 0;
                end
                if (first_pending) begin
                    first_pending = 0;
                    if (lat_chk) check("first_lat", cyc - go_cyc, 2);
                end
                last_strobe_cyc = cyc;
            end
            if (prev_busy && !busy && !skip_fall)
                check("busy_fall", cyc - last_strobe_cyc, 1);
        end
        prev_wstrb = oled_wstrb;
        prev_busy  = busy;
    end

    task automatic cpu_wr(input logic sc, input logic sw, input logic sg, input logic [31:0] d);
        bit do_abort;
        do_abort = 0;
        @(negedge clk);
        wstrb = 1'b1; sel_color = sc; sel_win = sw; sel_go = sg; wdata = d;
        if (!m_active) begin
            if (sc) m_colour = d[15:0];
            if (sw) m_win = {d[30:24], d[22:16], d[14:8], d[6:0]};
        end
        if (sg) begin
            if (d[31]) begin
                if (m_active) begin
                    do_abort  = 1;
                    skip_fall = 1;
                end
            end else if (!m_active && d[14:0] != 0) begin
`ifdef OLED_FILL_WINDOW_EN
                exp_q.push_back({2'b10, CMD_COL});
                exp_q.push_back({2'b01, 1'b0, m_win[6:0]});
                exp_q.push_back({2'b01, 1'b0, m_win[13:7]});
                exp_q.push_back({2'b10, CMD_ROW});
                exp_q.push_back({2'b01, 1'b0, m_win[20:14]});
                exp_q.push_back({2'b01, 1'b0, m_win[27:21]});
`endif
                exp_q.push_back({2'b10, CMD_WRAM});
                for (int i = 0; i < int'(d[14:0]); i++) begin
                    exp_q.push_back({2'b01, m_colour[15:8]});
                    exp_q.push_back({2'b01, m_colour[7:0]});
                end
                m_active        = 1;
                go_cyc          = cyc;
                first_pending   = 1;
                lat_chk         = (drv_cnt == 0) && !hold_busy;
                strobes_in_fill = 0;
                pix_seen        = 0;
                skip_fall       = 0;
            end
        end
        @(posedge clk);
        #1;
        wstrb = 1'b0; sel_color = 1'b0; sel_win = 1'b0; sel_go = 1'b0; wdata = '0;
        if (do_abort) begin
            exp_q.delete();
            m_active = 0;
        end
    endtask

    task automatic wait_drv();
        int n = 0;
        while (drv_cnt != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic start_fill(input int cnt);
        wait_drv();
        cpu_wr(1'b0, 1'b0, 1'b1, 32'(cnt) & 32'h0000_7FFF);
        check("busy_after_go", 32'(busy), (cnt != 0) ? 1 : 0);
    endtask

    task automatic wait_done(input int max_cyc);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check("done_in_time", 32'(n < max_cyc), 1);
        check("bytes_left", exp_q.size(), 0);
    endtask

    task automatic wait_pix(input int target);
        int n = 0;
        while (pix_seen < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("reach_pix", pix_seen, target);
    endtask

    task automatic check_outputs_zero(input string tag);
        check(tag, {27'd0, busy, oled_wstrb, oled_cmd, oled_dat, |oled_byte}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int cnt;
        logic [31:0] d;
        resetn = 1'b1; wstrb = 1'b0; sel_color = 1'b0; sel_win = 1'b0; sel_go = 1'b0;
        wdata = '0; hold_busy = 1'b0; drv_lat = 16;
        m_colour = '0; m_win = '0; m_active = 0;
        #3 resetn = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset_outputs");
        #2 resetn = 1'b1;

        // single pixel red after reset
        cpu_wr(1'b1, 1'b0, 1'b0, 32'h0000_F800);
        start_fill(1);
        wait_done(3000);

        // full-panel window, three pixels
        cpu_wr(1'b0, 1'b1, 1'b0, 32'h7F00_7F00);
        cpu_wr(1'b1, 1'b0, 1'b0, 32'h0000_1234);
        s0 = n_strobes;
        start_fill(3);
        wait_done(3000);
        check("win_total", n_strobes - s0, SETUP_LEN + 6);

        // driver held busy after GO
        @(negedge clk) hold_busy = 1'b1;
        s0 = n_strobes;
        start_fill(1);
        repeat (100) @(negedge clk);
        check("held_no_strobe", n_strobes - s0, 0);
        hold_busy = 1'b0;
        repeat (10) @(negedge clk);
        check("one_after_release", n_strobes - s0, 1);
        wait_done(3000);

        // abort after fourth pixel byte, then a fresh fill
        drv_lat = 8;
        cpu_wr(1'b1, 1'b0, 1'b0, 32'h0000_07E0);
        start_fill(5);
        wait_pix(4);
        cpu_wr(1'b0, 1'b0, 1'b1, 32'h8000_0000);
        check("busy_after_abort", 32'(busy), 0);
        s0 = n_strobes;
        repeat (40) @(negedge clk);
        check("no_strobe_after_abort", n_strobes - s0, 0);
        start_fill(2);
        wait_done(3000);

        // abort while idle
        s0 = n_strobes;
        cpu_wr(1'b0, 1'b0, 1'b1, 32'h8000_0003);
        check("idle_abort_busy", 32'(busy), 0);
        repeat (20) @(negedge clk);
        check("idle_abort_no_strobe", n_strobes - s0, 0);

        // zero count and GO/colour during busy
        s0 = n_strobes;
        start_fill(0);
        repeat (20) @(negedge clk);
        check("zero_count_no_strobe", n_strobes - s0, 0);
        s0 = n_strobes;
        start_fill(3);
        repeat (5) @(negedge clk);
        cpu_wr(1'b0, 1'b0, 1'b1, 32'h0000_0007);
        check("busy_go_ignored", 32'(busy), 1);
        cpu_wr(1'b1, 1'b1, 1'b0, 32'h1234_5678);
        wait_done(3000);
        check("go_busy_total", n_strobes - s0, SETUP_LEN + 6);

        // reset mid-pixel
        drv_lat = 4;
        cpu_wr(1'b1, 1'b0, 1'b0, 32'h0000_ABCD);
        start_fill(4);
        wait_pix(1);
        @(negedge clk);
        #2;
        skip_fall = 1;
        resetn = 1'b0;
        #1;
        check_outputs_zero("async_reset_outputs");
        exp_q.delete();
        m_active = 0; m_colour = '0; m_win = '0; first_pending = 0;
        repeat (2) @(negedge clk);
        #2 resetn = 1'b1;
        start_fill(1);
        wait_done(3000);

        // randomized fills
        for (int it = 0; it < 10; it++) begin
            cnt     = $urandom_range(0, 4);
            drv_lat = $urandom_range(0, 16);
            wait_drv();
            if ($urandom_range(0, 1) == 0) begin
                cpu_wr(1'b1, 1'b0, 1'b0, $urandom);
                if ($urandom_range(0, 1) == 0) cpu_wr(1'b0, 1'b1, 1'b0, $urandom);
                start_fill(cnt);
            end else begin
                d = $urandom;
                d[31] = 1'b0;
                d[14:0] = 15'(cnt);
                cpu_wr(1'b1, 1'b1, 1'b1, d);
                check("busy_after_combined_go", 32'(busy), (cnt != 0) ? 1 : 0);
            end
            if (cnt >= 3) begin
                repeat (3) @(negedge clk);
                d = $urandom;
                d[31] = 1'b0;
                cpu_wr(1'b1, 1'b1, 1'b0, d);
            end
            wait_done(3000);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
